// File: rtl/ex_mc_if.sv
// ID/EX -> EX/MEM handshake bundle for the multi-cycle execute stage.
// master = issuing (ID) side, slave = execute stage.
interface ex_mc_if #(
  parameter int DATA_W  = 32,
  parameter int RADDR_W = 5
);
  logic               valid_i;
  logic [3:0]         aluop_i;
  logic [DATA_W-1:0]  reg1_i;
  logic [DATA_W-1:0]  reg2_i;
  logic [RADDR_W-1:0] wd_i;
  logic               wreg_i;
  logic               stall_i;
  logic               flush_i;
  logic               stallreq_o;
  logic               valid_o;
  logic [RADDR_W-1:0] wd_o;
  logic               wreg_o;
  logic [DATA_W-1:0]  wdata_o;
  logic               ov_o;
  logic               whilo_o;
  logic [DATA_W-1:0]  hi_o;
  logic [DATA_W-1:0]  lo_o;

  modport master (
    output valid_i, aluop_i, reg1_i, reg2_i, wd_i, wreg_i, stall_i, flush_i,
    input  stallreq_o, valid_o, wd_o, wreg_o, wdata_o, ov_o, whilo_o, hi_o, lo_o
  );

  modport slave (
    input  valid_i, aluop_i, reg1_i, reg2_i, wd_i, wreg_i, stall_i, flush_i,
    output stallreq_o, valid_o, wd_o, wreg_o, wdata_o, ov_o, whilo_o, hi_o, lo_o
  );
endinterface

// File: rtl/ex_mc.sv
// Multi-cycle execute stage: single-cycle logic/arith ops plus an iterative
// restoring DIV/DIVU writing HI/LO, registered into the EX/MEM boundary.
module ex_mc #(
  parameter int DATA_W  = 32,
  parameter int RADDR_W = 5,
  parameter int CNT_W   = 6
) (
  input logic    clk,
  input logic    rst,
  ex_mc_if.slave bus
);

  localparam logic [3:0] OP_OR   = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_XOR  = 4'd3;
  localparam logic [3:0] OP_ADD  = 4'd4;
  localparam logic [3:0] OP_ADDU = 4'd5;
  localparam logic [3:0] OP_SUB  = 4'd6;
  localparam logic [3:0] OP_SLT  = 4'd7;
  localparam logic [3:0] OP_DIVU = 4'd8;
  localparam logic [3:0] OP_DIV  = 4'd9;
  localparam int         M       = DATA_W - 1;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {IDLE, DIV, DONE} state_t;

  function automatic logic [DATA_W-1:0] neg_if(input logic [DATA_W-1:0] v, input logic n);
    return n ? -v : v;
  endfunction

  function automatic logic [DATA_W-1:0] mag(input logic [DATA_W-1:0] v, input logic is_signed);
    return neg_if(v, is_signed && v[M]);
  endfunction

  // Overflow when both addends share a sign that the wrapped sum does not.
  function automatic logic add_ovf(input logic a_s, input logic b_s, input logic r_s);
    return (a_s == b_s) && (r_s != a_s);
  endfunction

  state_t              state, state_nxt;
  logic [CNT_W-1:0]    cnt;

  logic                is_div_op, div_req, b_zero, sdiv;
  logic [DATA_W-1:0]   b_neg, sum, dif;
  logic signed [M:0]   a_s, b_s;
  logic [DATA_W-1:0]   alu_res;
  logic                alu_ovf, alu_vld;

  logic [DATA_W-1:0]   rem_p0, quo_p0, dvs_p0;
  logic                neg_q_p0, neg_r_p0, dz_p0;
  logic [RADDR_W-1:0]  wd_div_p0;
  logic [DATA_W:0]     rem_sh, rem_try;
  logic [DATA_W-1:0]   q_fin, r_fin;

  logic                vld_p1, wreg_p1, ov_p1, whilo_p1;
  logic [RADDR_W-1:0]  wd_p1;
  logic [DATA_W-1:0]   wdata_p1, hi_p1, lo_p1;

  assign is_div_op = (bus.aluop_i == OP_DIVU) || (bus.aluop_i == OP_DIV);
  assign div_req   = bus.valid_i && is_div_op;
  assign b_zero    = (bus.reg2_i == '0);
  assign sdiv      = (bus.aluop_i == OP_DIV);

  assign bus.stallreq_o = ((state == IDLE) && div_req) || (state == DIV);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (state == DIV) cnt <= cnt + 1'b1;
      else              cnt <= '0;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (!bus.flush_i && div_req) state_nxt = b_zero ? DONE : DIV;
      DIV: begin
        if (bus.flush_i)             state_nxt = IDLE;
        else if (cnt == LAST_STEP)   state_nxt = DONE;
      end
      DONE: if (bus.flush_i || !bus.stall_i) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Stage p0: single-cycle ALU result and overflow
  assign a_s   = bus.reg1_i;
  assign b_s   = bus.reg2_i;
  assign b_neg = -bus.reg2_i;
  assign sum   = bus.reg1_i + bus.reg2_i;
  assign dif   = bus.reg1_i + b_neg;

  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    alu_vld = bus.valid_i;
    unique case (bus.aluop_i)
      OP_OR:   alu_res = bus.reg1_i | bus.reg2_i;
      OP_AND:  alu_res = bus.reg1_i & bus.reg2_i;
      OP_XOR:  alu_res = bus.reg1_i ^ bus.reg2_i;
      OP_ADD: begin
        alu_res = sum;
        alu_ovf = add_ovf(bus.reg1_i[M], bus.reg2_i[M], sum[M]);
      end
      OP_ADDU: alu_res = sum;
      OP_SUB: begin
        alu_res = dif;
        alu_ovf = add_ovf(bus.reg1_i[M], b_neg[M], dif[M]);
      end
      OP_SLT:  alu_res = {{(DATA_W-1){1'b0}}, (a_s < b_s)};
      default: alu_vld = 1'b0;
    endcase
  end

  // Stage p0: divider datapath, one restoring step per DIV cycle
  assign rem_sh  = {rem_p0, quo_p0[M]};
  assign rem_try = rem_sh - {1'b0, dvs_p0};
  assign q_fin   = dz_p0 ? '1     : neg_if(quo_p0, neg_q_p0);
  assign r_fin   = dz_p0 ? quo_p0 : neg_if(rem_p0, neg_r_p0);

  always_ff @(posedge clk) begin
    if (state == IDLE && div_req) begin
      dvs_p0    <= mag(bus.reg2_i, sdiv);
      quo_p0    <= b_zero ? bus.reg1_i : mag(bus.reg1_i, sdiv);
      rem_p0    <= '0;
      neg_q_p0  <= sdiv && (bus.reg1_i[M] ^ bus.reg2_i[M]);
      neg_r_p0  <= sdiv && bus.reg1_i[M];
      dz_p0     <= b_zero;
      wd_div_p0 <= bus.wd_i;
    end else if (state == DIV) begin
      if (!rem_try[DATA_W]) begin
        rem_p0 <= rem_try[M:0];
        quo_p0 <= {quo_p0[M-1:0], 1'b1};
      end else begin
        rem_p0 <= rem_sh[M:0];
        quo_p0 <= {quo_p0[M-1:0], 1'b0};
      end
    end
  end

  // Stage p1: EX/MEM output register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1   <= 1'b0;
      wd_p1    <= '0;
      wreg_p1  <= 1'b0;
      wdata_p1 <= '0;
      ov_p1    <= 1'b0;
      whilo_p1 <= 1'b0;
      hi_p1    <= '0;
      lo_p1    <= '0;
    end else if (bus.flush_i) begin
      vld_p1   <= 1'b0;
      wreg_p1  <= 1'b0;
      ov_p1    <= 1'b0;
      whilo_p1 <= 1'b0;
    end else if (!bus.stall_i) begin
      if (state == DONE) begin
        vld_p1   <= 1'b1;
        wd_p1    <= wd_div_p0;
        wreg_p1  <= 1'b0;
        wdata_p1 <= '0;
        ov_p1    <= 1'b0;
        whilo_p1 <= 1'b1;
        hi_p1    <= r_fin;
        lo_p1    <= q_fin;
      end else if (state == IDLE && alu_vld) begin
        vld_p1   <= 1'b1;
        wd_p1    <= bus.wd_i;
        wreg_p1  <= bus.wreg_i && !alu_ovf;
        wdata_p1 <= alu_res;
        ov_p1    <= alu_ovf;
        whilo_p1 <= 1'b0;
      end else begin
        vld_p1   <= 1'b0;
        wreg_p1  <= 1'b0;
        ov_p1    <= 1'b0;
        whilo_p1 <= 1'b0;
      end
    end
  end

  assign bus.valid_o = vld_p1;
  assign bus.wd_o    = wd_p1;
  assign bus.wreg_o  = wreg_p1;
  assign bus.wdata_o = wdata_p1;
  assign bus.ov_o    = ov_p1;
  assign bus.whilo_o = whilo_p1;
  assign bus.hi_o    = hi_p1;
  assign bus.lo_o    = lo_p1;

endmodule

// File: tb/tb_ex_mc.sv
// Scoreboard bench for ex_mc: directed corner cases, then randomized ops
// checked against an arithmetic reference model.
module tb_ex_mc;
  localparam int DW = 32;
  localparam int AW = 5;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ex_mc_if #(.DATA_W(DW), .RADDR_W(AW)) bus ();
  ex_mc #(.DATA_W(DW), .RADDR_W(AW), .CNT_W(6)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic [4:0]  wd;
    logic        wreg;
    logic [31:0] wdata;
    logic        ov;
    logic        whilo;
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  logic [8:0]  s_ctl;
  logic [31:0] s_wdata;
  logic [63:0] s_hilo;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic exp_t model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                 input logic [4:0] wd, input logic wreg);
    exp_t        e;
    longint      sa, sb, s, q, r;
    logic [31:0] nb;
    logic signed [31:0] t;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    e.wd = wd; e.wreg = wreg; e.wdata = 32'd0; e.ov = 1'b0; e.whilo = 1'b0;
    e.hi = 32'd0; e.lo = 32'd0;
    case (op)
      4'd1: e.wdata = a | b;
      4'd2: e.wdata = a & b;
      4'd3: e.wdata = a ^ b;
      4'd4, 4'd6: begin
        nb = (op == 4'd4) ? b : (32'd0 - b);
        s  = sa + longint'($signed(nb));
        t  = s[31:0];
        e.wdata = t;
        e.ov    = (longint'(t) != s);
        e.wreg  = wreg && !e.ov;
      end
      4'd5: e.wdata = a + b;
      4'd7: e.wdata = (sa < sb) ? 32'd1 : 32'd0;
      4'd8, 4'd9: begin
        e.wreg = 1'b0; e.whilo = 1'b1;
        if (b == 32'd0) begin
          e.lo = 32'hFFFF_FFFF; e.hi = a;
        end else if (op == 4'd8) begin
          e.lo = a / b; e.hi = a % b;
        end else begin
          q = sa / sb; r = sa % sb;
          e.lo = q[31:0]; e.hi = r[31:0];
        end
      end
      default: e.wreg = 1'b0;
    endcase
    return e;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      5: return 32'($urandom_range(0, 20));
      default: return $urandom();
    endcase
  endfunction

  // Present one op and hold it until ID would release it; rnd toggles stall_i.
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] wd, input logic wreg, input logic vld,
                       input bit rnd, output int sc);
    bit done;
    done = 0;
    sc   = 0;
    bus.valid_i = vld; bus.aluop_i = op; bus.reg1_i = a; bus.reg2_i = b;
    bus.wd_i = wd; bus.wreg_i = wreg;
    if (rnd) bus.stall_i = ($urandom_range(0, 3) == 0);
    for (int n = 0; n < 200 && !done; n++) begin
      @(negedge clk);
      if (bus.stallreq_o) sc++;
      if (!bus.stallreq_o && !bus.stall_i) begin
        done = 1;
        if (vld && op >= 4'd1 && op <= 4'd9) exp_q.push_back(model(op, a, b, wd, wreg));
      end
      @(posedge clk);
      #1;
      if (!done && rnd) bus.stall_i = ($urandom_range(0, 3) == 0);
    end
    if (!done) chk("issue_timeout", 64'(done), 64'(1));
    bus.valid_i = 1'b0;
  endtask

  // Monitor: compare each newly registered output against the scoreboard.
  initial begin
    exp_t e;
    logic last_stall, last_flush;
    last_stall = 1'b0; last_flush = 1'b0;
    s_ctl = '0; s_wdata = '0; s_hilo = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        last_stall = 1'b0; last_flush = 1'b0;
      end else if (last_flush) begin
        chk("flush_valid", 64'(bus.valid_o), 64'(0));
        chk("flush_whilo", 64'(bus.whilo_o), 64'(0));
      end else if (last_stall) begin
        chk("hold_ctl", 64'({bus.valid_o, bus.wd_o, bus.wreg_o, bus.ov_o, bus.whilo_o}), 64'(s_ctl));
        chk("hold_wdata", 64'(bus.wdata_o), 64'(s_wdata));
        chk("hold_hilo", {bus.hi_o, bus.lo_o}, s_hilo);
      end else if (bus.valid_o) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_output", 64'(bus.valid_o), 64'(0));
        end else begin
          e = exp_q.pop_front();
          chk("wd", 64'(bus.wd_o), 64'(e.wd));
          chk("wreg", 64'(bus.wreg_o), 64'(e.wreg));
          chk("wdata", 64'(bus.wdata_o), 64'(e.wdata));
          chk("ov", 64'(bus.ov_o), 64'(e.ov));
          chk("whilo", 64'(bus.whilo_o), 64'(e.whilo));
          if (e.whilo) begin
            chk("hi", 64'(bus.hi_o), 64'(e.hi));
            chk("lo", 64'(bus.lo_o), 64'(e.lo));
          end
        end
      end
      s_ctl      = {bus.valid_o, bus.wd_o, bus.wreg_o, bus.ov_o, bus.whilo_o};
      s_wdata    = bus.wdata_o;
      s_hilo     = {bus.hi_o, bus.lo_o};
      last_stall = bus.stall_i;
      last_flush = bus.flush_i;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int sc;
    logic [3:0] op;
    rst = 1'b1;
    bus.valid_i = 0; bus.aluop_i = 0; bus.reg1_i = 0; bus.reg2_i = 0;
    bus.wd_i = 0; bus.wreg_i = 0; bus.stall_i = 0; bus.flush_i = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", 64'(bus.valid_o), 64'(0));
    chk("rst_wreg", 64'(bus.wreg_o), 64'(0));
    chk("rst_whilo", 64'(bus.whilo_o), 64'(0));
    chk("rst_ov", 64'(bus.ov_o), 64'(0));
    chk("rst_wdata", 64'(bus.wdata_o), 64'(0));
    chk("rst_hilo", {bus.hi_o, bus.lo_o}, 64'(0));
    chk("rst_stallreq", 64'(bus.stallreq_o), 64'(0));
    @(posedge clk);
    #1 rst = 1'b0;

    issue(4'd4, 32'h7FFF_FFFF, 32'd1, 5'd3, 1'b1, 1'b1, 0, sc);
    issue(4'd7, 32'hFFFF_FFFF, 32'd1, 5'd4, 1'b1, 1'b1, 0, sc);
    issue(4'd5, 32'hFFFF_FFFF, 32'd1, 5'd5, 1'b1, 1'b1, 0, sc);
    issue(4'd6, 32'h8000_0000, 32'd1, 5'd6, 1'b1, 1'b1, 0, sc);
    issue(4'd9, 32'hFFFF_FFF9, 32'd2, 5'd7, 1'b1, 1'b1, 0, sc);
    chk("div_stall_cycles", 64'(sc), 64'(33));
    issue(4'd8, 32'd5, 32'd0, 5'd8, 1'b1, 1'b1, 0, sc);
    chk("divz_stall_cycles", 64'(sc), 64'(1));
    issue(4'd9, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9, 1'b1, 1'b1, 0, sc);
    issue(4'd0, 32'd12, 32'd34, 5'd10, 1'b1, 1'b1, 0, sc);
    issue(4'd2, 32'hF0F0_1234, 32'h0FF0_FFFF, 5'd11, 1'b1, 1'b1, 0, sc);

    // Flush a divide part-way through.
    bus.valid_i = 1; bus.aluop_i = 4'd9; bus.reg1_i = 32'd1000; bus.reg2_i = 32'd3;
    bus.wd_i = 5'd12; bus.wreg_i = 1;
    repeat (11) @(posedge clk);
    @(negedge clk);
    chk("pre_flush_stallreq", 64'(bus.stallreq_o), 64'(1));
    @(posedge clk);
    #1 bus.valid_i = 0; bus.flush_i = 1;
    @(posedge clk);
    #1 bus.flush_i = 0;
    @(negedge clk);
    chk("post_flush_stallreq", 64'(bus.stallreq_o), 64'(0));
    repeat (40) @(posedge clk);
    #1;
    issue(4'd1, 32'hA500_0000, 32'h0000_005A, 5'd13, 1'b1, 1'b1, 0, sc);

    // Downstream stall held across the DONE state.
    fork
      issue(4'd8, 32'd1000, 32'd7, 5'd14, 1'b1, 1'b1, 0, sc);
      begin
        repeat (20) @(posedge clk);
        #1 bus.stall_i = 1;
        for (int n = 0; n < 100; n++) begin
          @(negedge clk);
          if (!bus.stallreq_o) break;
        end
        repeat (3) @(posedge clk);
        #1 bus.stall_i = 0;
      end
    join
    issue(4'd3, 32'h1234_5678, 32'hFFFF_0000, 5'd15, 1'b1, 1'b1, 0, sc);

    for (int i = 0; i < 150; i++) begin
      op = 4'($urandom_range(0, 15));
      issue(op, pick(), pick(), 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 7) != 0), 1, sc);
    end
    bus.stall_i = 0;

    // Asynchronous reset in the middle of a divide.
    issue(4'd8, 32'd100, 32'd7, 5'd16, 1'b1, 1'b1, 0, sc);
    repeat (3) @(posedge clk);
    #1 bus.valid_i = 1; bus.aluop_i = 4'd9; bus.reg1_i = 32'hFFFF_FFCE; bus.reg2_i = 32'd3;
    repeat (6) @(posedge clk);
    @(negedge clk);
    chk("mid_div_stallreq", 64'(bus.stallreq_o), 64'(1));
    #2 rst = 1'b1; bus.valid_i = 0;
    #1;
    chk("arst_valid", 64'(bus.valid_o), 64'(0));
    chk("arst_whilo", 64'(bus.whilo_o), 64'(0));
    chk("arst_hilo", {bus.hi_o, bus.lo_o}, 64'(0));
    chk("arst_wdata", 64'(bus.wdata_o), 64'(0));
    chk("arst_stallreq", 64'(bus.stallreq_o), 64'(0));
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    issue(4'd9, 32'd77, 32'hFFFF_FFF6, 5'd17, 1'b1, 1'b1, 0, sc);
    issue(4'd6, 32'd5, 32'd9, 5'd18, 1'b1, 1'b1, 0, sc);

    repeat (5) @(posedge clk);
    chk("scoreboard_drained", 64'(exp_q.size()), 64'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
